// File: rtl/sc_spi_pkg.sv
// Shared types and constants for the SPI multi-word transfer sequencer.
// Holds the FSM encoding plus default buffer depth and data width.
package sc_spi_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = 3;
    localparam int DW        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

endpackage

// File: rtl/sc_spi_sfifo.sv
// Synchronous first-word-fall-through FIFO used for the TX and RX buffers.
// Pushes when full and pops when empty are silently dropped.
module sc_spi_sfifo
    import sc_spi_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int W     = DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_level == LP_DEPTH);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_level = r_level;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sc_spi_xfer_seq.sv
// Burst sequencer in front of the SPI engine: feeds TX words one at a time,
// keeps CS asserted between words and collects replies into the RX buffer.
module sc_spi_xfer_seq
    import sc_spi_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          SYSCLK,
    input  logic          SYSRST,
    input  logic [31:0]   WDATA,
    input  logic          WVALID,
    output logic          WREADY,
    output logic [31:0]   RDATA,
    output logic          RVALID,
    input  logic          RREADY,
    input  logic [AW:0]   NWORDS,
    input  logic          KEEPCS,
    input  logic          GO,
    output logic [AW:0]   TXLEVEL,
    output logic [AW:0]   RXLEVEL,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic          TXSTART,
    output logic          CSEXTEND,
    output logic [31:0]   TXDATA,
    input  logic          SPIBUSY,
    input  logic          SPICOMPLETE,
    input  logic [31:0]   RXDATA
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW:0]   r_rem;
    logic [AW:0]   w_rem_nx;
    logic          r_kc;
    logic          w_kc_nx;
    logic [31:0]   r_txdata;
    logic [31:0]   w_txdata_nx;
    logic          r_csext;
    logic          w_csext_nx;
    logic          r_txstart;
    logic          w_txstart_nx;
    logic          r_done;
    logic          w_done_nx;
    logic          r_err;
    logic          w_err_nx;

    logic          w_tx_pop;
    logic          w_rx_push;
    logic [31:0]   w_tx_head;
    logic          w_tx_empty;
    logic          w_rx_empty;
    logic          w_go_ok;

    sc_spi_sfifo #(.DEPTH(DEPTH), .AW(AW), .W(DW)) u_txf (
        .i_clk   (SYSCLK),
        .i_rst   (SYSRST),
        .i_push  (WVALID),
        .i_wdata (WDATA),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_empty (w_tx_empty),
        .o_level (TXLEVEL)
    );

    sc_spi_sfifo #(.DEPTH(DEPTH), .AW(AW), .W(DW)) u_rxf (
        .i_clk   (SYSCLK),
        .i_rst   (SYSRST),
        .i_push  (w_rx_push),
        .i_wdata (RXDATA),
        .i_pop   (RREADY),
        .o_rdata (RDATA),
        .o_empty (w_rx_empty),
        .o_level (RXLEVEL)
    );

    // RX room for the whole burst is reserved up front
    assign w_go_ok = (NWORDS != '0) && (NWORDS <= LP_DEPTH) &&
                     (TXLEVEL >= NWORDS) &&
                     ((LP_DEPTH - RXLEVEL) >= NWORDS);

    always_comb begin
        w_state_nx   = r_state;
        w_rem_nx     = r_rem;
        w_kc_nx      = r_kc;
        w_txdata_nx  = r_txdata;
        w_csext_nx   = r_csext;
        w_txstart_nx = 1'b0;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (GO) begin
                    if (w_go_ok) begin
                        w_rem_nx   = NWORDS;
                        w_kc_nx    = KEEPCS;
                        w_state_nx = ST_ARM;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (!SPIBUSY && !w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_txdata_nx  = w_tx_head;
                    w_csext_nx   = (r_rem > LP_ONE) | r_kc;
                    w_txstart_nx = 1'b1;
                    w_state_nx   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a completion coincident with our start is from a stale word
                if (SPICOMPLETE && !r_txstart) begin
                    w_rx_push  = 1'b1;
                    w_rem_nx   = r_rem - LP_ONE;
                    w_state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_rem == '0) begin
                    w_done_nx  = 1'b1;
                    w_csext_nx = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_ARM;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_kc      <= 1'b0;
            r_txdata  <= '0;
            r_csext   <= 1'b0;
            r_txstart <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rem     <= w_rem_nx;
            r_kc      <= w_kc_nx;
            r_txdata  <= w_txdata_nx;
            r_csext   <= w_csext_nx;
            r_txstart <= w_txstart_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
        end
    end

    assign WREADY   = (TXLEVEL != LP_DEPTH);
    assign RVALID   = ~w_rx_empty;
    assign BUSY     = (r_state != ST_IDLE);
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign TXSTART  = r_txstart;
    assign CSEXTEND = r_csext;
    assign TXDATA   = r_txdata;

endmodule

// File: tb/tb_sc_spi_xfer_seq.sv
// Self-checking bench for sc_spi_xfer_seq with a simple SPI engine model
// and TX/RX/CS scoreboards.
module tb_sc_spi_xfer_seq;

    localparam int ENG_LAT = 6;

    logic        SYSCLK = 1'b0;
    logic        SYSRST;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic [3:0]  NWORDS;
    logic        KEEPCS;
    logic        GO;
    logic [3:0]  TXLEVEL;
    logic [3:0]  RXLEVEL;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        TXSTART;
    logic        CSEXTEND;
    logic [31:0] TXDATA;
    logic        SPIBUSY;
    logic        SPICOMPLETE;
    logic [31:0] RXDATA;

    logic        eng_busy;
    logic        force_busy;
    logic [31:0] eng_word;

    int n_chk  = 0;
    int n_fail = 0;
    int n_txstart = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        cs_q[$];

    typedef struct {
        int npush;
        int nw;
        bit kc;
        bit err;
    } vec_t;

    vec_t tbl[5];

    assign SPIBUSY = eng_busy | force_busy;

    always #5 SYSCLK = ~SYSCLK;

    sc_spi_xfer_seq dut (
        .SYSCLK      (SYSCLK),
        .SYSRST      (SYSRST),
        .WDATA       (WDATA),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .NWORDS      (NWORDS),
        .KEEPCS      (KEEPCS),
        .GO          (GO),
        .TXLEVEL     (TXLEVEL),
        .RXLEVEL     (RXLEVEL),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR),
        .TXSTART     (TXSTART),
        .CSEXTEND    (CSEXTEND),
        .TXDATA      (TXDATA),
        .SPIBUSY     (SPIBUSY),
        .SPICOMPLETE (SPICOMPLETE),
        .RXDATA      (RXDATA)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge SYSCLK);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_wready"}, 32'(WREADY), 32'd1);
        chk({tag, "_rvalid"}, 32'(RVALID), 32'd0);
        chk({tag, "_rdata"}, RDATA, 32'd0);
        chk({tag, "_txlevel"}, 32'(TXLEVEL), 32'd0);
        chk({tag, "_rxlevel"}, 32'(RXLEVEL), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_txstart"}, 32'(TXSTART), 32'd0);
        chk({tag, "_csextend"}, 32'(CSEXTEND), 32'd0);
        chk({tag, "_txdata"}, TXDATA, 32'd0);
    endtask

    task automatic push_tx(logic [31:0] w);
        WDATA  = w;
        WVALID = 1'b1;
        tx_q.push_back(w);
        rx_q.push_back(~w);
        tick();
        WVALID = 1'b0;
    endtask

    task automatic go(int n, bit kc);
        NWORDS = 4'(n);
        KEEPCS = kc;
        GO     = 1'b1;
        tick();
        GO     = 1'b0;
    endtask

    task automatic expect_cs(int n, bit kc);
        for (int i = 0; i < n; i++) begin
            cs_q.push_back(((n - i) > 1) | kc);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (DONE !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("busy_at_done", 32'(BUSY), 32'd0);
        chk("cs_at_done", 32'(CSEXTEND), 32'd0);
        tick();
        chk("done_single", 32'(DONE), 32'd0);
    endtask

    task automatic drain_rx(int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            chk("rx_valid", 32'(RVALID), 32'd1);
            e = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
            chk("rx_data", RDATA, e);
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
    endtask

    // engine model: answers each start with ~TXDATA after ENG_LAT cycles
    initial begin
        SPICOMPLETE = 1'b0;
        RXDATA      = '0;
        eng_busy    = 1'b0;
        forever begin
            @(negedge SYSCLK);
            if (TXSTART === 1'b1 && SYSRST === 1'b0) begin
                eng_word = TXDATA;
                eng_busy = 1'b1;
                repeat (ENG_LAT) @(negedge SYSCLK);
                RXDATA      = ~eng_word;
                SPICOMPLETE = 1'b1;
                eng_busy    = 1'b0;
                @(negedge SYSCLK);
                SPICOMPLETE = 1'b0;
            end
        end
    end

    // TX/CS scoreboard and hold check while a word is in flight
    initial begin
        logic        hold;
        logic [31:0] hold_w;
        logic [31:0] e;
        logic        ec;
        hold = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge SYSCLK);
            if (SYSRST === 1'b1) begin
                hold = 1'b0;
            end else if (TXSTART === 1'b1) begin
                n_txstart++;
                e  = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hDEAD_BEEF;
                ec = (cs_q.size() > 0) ? cs_q.pop_front() : 1'bx;
                chk("txdata", TXDATA, e);
                chk("csextend", 32'(CSEXTEND), 32'(ec));
                hold_w = e;
                hold   = 1'b1;
            end else if (hold) begin
                chk("txdata_hold", TXDATA, hold_w);
                if (SPICOMPLETE === 1'b1) hold = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int mdl_tx;
        int base;
        int t;
        int popped;
        int pushed;
        logic [31:0] e;

        SYSRST     = 1'b1;
        WDATA      = '0;
        WVALID     = 1'b0;
        RREADY     = 1'b0;
        NWORDS     = '0;
        KEEPCS     = 1'b0;
        GO         = 1'b0;
        force_busy = 1'b0;
        mdl_tx     = 0;

        tbl[0] = '{npush: 3, nw: 3, kc: 1'b0, err: 1'b0};
        tbl[1] = '{npush: 2, nw: 4, kc: 1'b0, err: 1'b1};
        tbl[2] = '{npush: 0, nw: 0, kc: 1'b0, err: 1'b1};
        tbl[3] = '{npush: 0, nw: 2, kc: 1'b1, err: 1'b0};
        tbl[4] = '{npush: 0, nw: 9, kc: 1'b0, err: 1'b1};

        repeat (3) tick();
        chk_reset("rst");
        SYSRST = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < tbl[v].npush; i++) begin
                push_tx(32'hA5A5_0001 + 32'(mdl_tx + i));
            end
            mdl_tx += tbl[v].npush;
            base = n_txstart;
            if (!tbl[v].err) expect_cs(tbl[v].nw, tbl[v].kc);
            go(tbl[v].nw, tbl[v].kc);
            chk("err_pulse", 32'(ERR), 32'(tbl[v].err));
            if (tbl[v].err) begin
                tick();
                chk("err_single", 32'(ERR), 32'd0);
                repeat (4) tick();
                chk("no_txstart", 32'(n_txstart - base), 32'd0);
                chk("txlevel_kept", 32'(TXLEVEL), 32'(mdl_tx));
            end else begin
                wait_done();
                mdl_tx -= tbl[v].nw;
                chk("burst_starts", 32'(n_txstart - base), 32'(tbl[v].nw));
                chk("txlevel_after", 32'(TXLEVEL), 32'(mdl_tx));
                chk("rxlevel_after", 32'(RXLEVEL), 32'(tbl[v].nw));
                drain_rx(tbl[v].nw);
            end
        end

        for (int i = 0; i < 8; i++) push_tx(32'hC0DE_0000 + 32'(i));
        chk("full_wready", 32'(WREADY), 32'd0);
        WDATA  = 32'hBAD0_BAD0;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("full_drop", 32'(TXLEVEL), 32'd8);
        base = n_txstart;
        expect_cs(8, 1'b1);
        go(8, 1'b1);
        wait_done();
        chk("full_starts", 32'(n_txstart - base), 32'd8);
        chk("rx_full_level", 32'(RXLEVEL), 32'd8);
        push_tx(32'h1234_5678);
        go(1, 1'b0);
        chk("rx_full_err", 32'(ERR), 32'd1);
        tick();
        chk("rx_full_txlvl", 32'(TXLEVEL), 32'd1);
        drain_rx(8);

        force_busy = 1'b1;
        expect_cs(1, 1'b0);
        go(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("start_blocked", 32'(TXSTART), 32'd0);
            tick();
        end
        force_busy = 1'b0;
        tick();
        chk("start_on_release", 32'(TXSTART), 32'd1);
        wait_done();
        drain_rx(1);

        for (int i = 0; i < 4; i++) push_tx(32'h7700_0000 + 32'(i));
        expect_cs(4, 1'b0);
        base   = n_txstart;
        popped = 0;
        pushed = 0;
        go(4, 1'b0);
        t = 0;
        while (DONE !== 1'b1 && t < 300) begin
            if (RVALID === 1'b1) begin
                e = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
                chk("conc_rx_data", RDATA, e);
                RREADY = 1'b1;
                popped++;
            end else begin
                RREADY = 1'b0;
            end
            if ((t % 7) == 3 && pushed < 3) begin
                WDATA  = 32'h9900_0000 + 32'(pushed);
                WVALID = 1'b1;
                tx_q.push_back(WDATA);
                rx_q.push_back(~WDATA);
                pushed++;
            end else begin
                WVALID = 1'b0;
            end
            tick();
            t++;
        end
        RREADY = 1'b0;
        WVALID = 1'b0;
        wait_done();
        chk("conc_starts", 32'(n_txstart - base), 32'd4);
        chk("conc_txlevel", 32'(TXLEVEL), 32'd3);
        chk("conc_rxlevel", 32'(RXLEVEL), 32'(4 - popped));
        drain_rx(4 - popped);

        expect_cs(3, 1'b0);
        base = n_txstart;
        go(3, 1'b0);
        t = 0;
        while (n_txstart < base + 2 && t < 200) begin
            tick();
            t++;
        end
        chk("rst_reach_w2", 32'(n_txstart - base), 32'd2);
        tick();
        SYSRST = 1'b1;
        tick();
        chk_reset("midrst");
        tick();
        SYSRST = 1'b0;
        tx_q.delete();
        rx_q.delete();
        cs_q.delete();
        repeat (12) tick();
        chk("midrst_rxlevel", 32'(RXLEVEL), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_starts", 32'(n_txstart - base), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
